// File: rtl/ao_pmu_seq.sv
// ao_pmu_seq: always-on power sequencer for regulator enables, isolation and SoC reset
module ao_pmu_seq #(
    parameter int CW   = 16,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sleep_req,
    input  logic          wkup,
    input  logic          bgrdy,
    input  logic          vr25rdy,
    input  logic          vr85ardy,
    input  logic          vr85drdy,
    input  logic          cfg_keep25,
    input  logic [CW-1:0] cfg_tmo,
    input  logic [CW-1:0] cfg_settle,
    input  logic [CW-1:0] cfg_dndly,
    input  logic          fault_clr,
    output logic          vr25ena,
    output logic          vr85aena,
    output logic          vr85dena,
    output logic          iso_enable,
    output logic          soc_rstn,
    output logic          busy,
    output logic          fault,
    output logic [1:0]    fault_src,
    output logic [3:0]    state
);
    typedef enum logic [3:0] {
        CHK, SETTLE, ON, DN_RST, DN_ISO, DN_85D, DN_85A, DN_25,
        OFF, UP_25, UP_85A, UP_85D, FAULT
    } state_t;

    state_t        cur, nxt;
    logic [3:0]    sync_q [SYNC];
    logic [3:0]    rdy;
    logic [CW-1:0] cnt;
    logic          wake_pend, tmo_hit, dn_hit;
    logic [1:0]    src;

    assign rdy     = sync_q[SYNC-1];
    assign state   = cur;
    assign busy    = !(cur inside {ON, OFF, FAULT});
    assign dn_hit  = cnt == cfg_dndly;
    assign tmo_hit = (cfg_tmo != '0) && (cnt == cfg_tmo) && !fault_clr;

    // ready synchronizer chain, bit order {85D, 85A, 25, BG}
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {vr85drdy, vr85ardy, vr25rdy, bgrdy};
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // next-state selection and timeout source capture
    always_comb begin
        nxt = cur;
        src = fault_src;
        case (cur)
            CHK: begin
                src = !rdy[0] ? 2'd0 : !rdy[1] ? 2'd1 : !rdy[2] ? 2'd2 : 2'd3;
                nxt = &rdy ? SETTLE : tmo_hit ? FAULT : CHK;
            end
            SETTLE: nxt = cnt == cfg_settle ? ON : SETTLE;
            ON:     nxt = sleep_req ? DN_RST : ON;
            DN_RST: nxt = dn_hit ? DN_ISO : DN_RST;
            DN_ISO: nxt = dn_hit ? DN_85D : DN_ISO;
            DN_85D: nxt = dn_hit ? DN_85A : DN_85D;
            DN_85A: nxt = dn_hit ? (cfg_keep25 ? OFF : DN_25) : DN_85A;
            DN_25:  nxt = dn_hit ? OFF : DN_25;
            OFF:    nxt = wake_pend ? (vr25ena ? UP_85A : UP_25) : OFF;
            UP_25: begin
                src = 2'd1;
                nxt = rdy[1] ? UP_85A : tmo_hit ? FAULT : UP_25;
            end
            UP_85A: begin
                src = 2'd2;
                nxt = rdy[2] ? UP_85D : tmo_hit ? FAULT : UP_85A;
            end
            UP_85D: begin
                src = 2'd3;
                nxt = rdy[3] ? SETTLE : tmo_hit ? FAULT : UP_85D;
            end
            FAULT:   nxt = fault_clr ? CHK : FAULT;
            default: nxt = CHK;
        endcase
    end

    // state, dwell counter and registered outputs updated on state entry
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= CHK;
            cnt        <= '0;
            vr25ena    <= 1'b1;
            vr85aena   <= 1'b1;
            vr85dena   <= 1'b1;
            iso_enable <= 1'b1;
            soc_rstn   <= 1'b0;
            fault      <= 1'b0;
            fault_src  <= 2'd0;
            wake_pend  <= 1'b0;
        end else begin
            cur        <= nxt;
            cnt        <= nxt != cur ? '0 : cnt + 1'b1;
            vr25ena    <= nxt == DN_25 ? 1'b0 : (nxt == UP_25 || nxt == FAULT) ? 1'b1 : vr25ena;
            vr85aena   <= nxt == DN_85A ? 1'b0 : (nxt == UP_85A || nxt == FAULT) ? 1'b1 : vr85aena;
            vr85dena   <= nxt == DN_85D ? 1'b0 : (nxt == UP_85D || nxt == FAULT) ? 1'b1 : vr85dena;
            iso_enable <= nxt == ON ? 1'b0 : (nxt == DN_ISO || nxt == FAULT) ? 1'b1 : iso_enable;
            soc_rstn   <= nxt == ON ? 1'b1 : (nxt == DN_RST || nxt == FAULT) ? 1'b0 : soc_rstn;
            fault      <= fault_clr ? 1'b0 : (nxt == FAULT && cur != FAULT) ? 1'b1 : fault;
            fault_src  <= (nxt == FAULT && cur != FAULT) ? src : fault_src;
            wake_pend  <= (cur == ON && !sleep_req) ? 1'b0 : wkup | (wake_pend && !(cur == OFF && nxt != OFF));
        end
    end
endmodule
